des_key_schedule: RTL

Round-key generator for the DES core. It loads a 64-bit key, applies PC-1, and on each start produces the 16 PC-2 round keys on consecutive cycles. It also drives `rkey_sel`, which is high for exactly the 16 round cycles. The encipher controller downstream keeps its process flag set until `rkey_sel` falls, so this block marks the end of every DES operation.

---
 rtl/des_key_schedule_pkg.sv | 55 +++++
 rtl/des_key_schedule_if.sv | 31 +++
 rtl/des_key_schedule_pc2.sv | 19 +
 rtl/des_key_schedule.sv | 133 +++++++++++++
 4 files changed

// File: rtl/des_key_schedule_pkg.sv
// DES key-schedule constants: PC-1/PC-2 tables, rotation schedule, FSM state.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package des_pkg;

  localparam int DES_ROUNDS = 16;

  typedef enum logic {IDLE, RUN} state_t;

  // PC-1: entry i gives the DES key bit (1 = MSB) that lands in C/D bit i+1.
  localparam logic [5:0] PC1_TAB [56] = '{
    6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,  6'd1,
    6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18, 6'd10, 6'd2,
    6'd59, 6'd51, 6'd43, 6'd35, 6'd27, 6'd19, 6'd11, 6'd3,
    6'd60, 6'd52, 6'd44, 6'd36, 6'd63, 6'd55, 6'd47, 6'd39,
    6'd31, 6'd23, 6'd15, 6'd7,  6'd62, 6'd54, 6'd46, 6'd38,
    6'd30, 6'd22, 6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37,
    6'd29, 6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
  };

  // PC-2: entry i gives the C/D bit (1 = MSB of C) that lands in round-key bit i+1.
  localparam logic [5:0] PC2_TAB [48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28,
    6'd15, 6'd6,  6'd21, 6'd10, 6'd23, 6'd19, 6'd12, 6'd4,
    6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40,
    6'd51, 6'd45, 6'd33, 6'd48, 6'd44, 6'd49, 6'd39, 6'd56,
    6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  // Left-rotation amount applied to reach round key n (index n-1).
  localparam logic [1:0] SHIFT_TAB [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  // Parity bits (8, 16, ..., 64) never appear in the table and drop out here.
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      r[6'(55 - i)] = k[6'(64 - int'(PC1_TAB[i]))];
    end
    return r;
  endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Control/data bundle between the DES key schedule and its controller.
// Latency: n/a (wiring only); decrypt exists only with DES_KEY_DECRYPT_EN.
// Backpressure: none; start/key_load are pulses, round keys stream out unthrottled.
interface des_key_schedule_if;
  logic        key_load;
  logic [63:0] key_in;
  logic        start;
`ifdef DES_KEY_DECRYPT_EN
  logic        decrypt;
`endif
  logic        rkey_sel;
  logic [47:0] rkey_out;
  logic [3:0]  round_idx;
  logic        rkey_done;

  modport master (
`ifdef DES_KEY_DECRYPT_EN
    output decrypt,
`endif
    output key_load, key_in, start,
    input  rkey_sel, rkey_out, round_idx, rkey_done
  );

  modport slave (
`ifdef DES_KEY_DECRYPT_EN
    input  decrypt,
`endif
    input  key_load, key_in, start,
    output rkey_sel, rkey_out, round_idx, rkey_done
  );
endinterface

// File: rtl/des_key_schedule_pc2.sv
// PC-2 compression permutation: 56-bit C/D to 48-bit round key.
// Latency: combinational.
// Backpressure: none.
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output logic [47:0] k
);

  // Pure bit selection through the PC-2 table
  always_comb begin
    k = '0;
    for (int i = 0; i < 48; i++) begin
      k[6'(47 - i)] = cd[6'(56 - int'(PC2_TAB[i]))];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// DES round-key generator: PC-1 on load, 16 PC-2 round keys per start.
// Latency: key n valid in cycle n after start is sampled; rkey_done one cycle after K16.
// Backpressure: none; start/key_load ignored while running. Option: DES_KEY_DECRYPT_EN.
module des_key_schedule
  import des_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  des_key_schedule_if.slave   bus
);

  state_t      state, state_nxt;
  logic [27:0] c0, d0, c0_nxt, d0_nxt;
  logic [27:0] c, d, c_nxt, d_nxt;
  logic [3:0]  round, round_nxt;
  logic        done, done_nxt;
  logic        last_round;
  logic        restore_ok;
  logic [55:0] key_pc1;
  logic [47:0] pc2_out;
`ifdef DES_KEY_DECRYPT_EN
  logic        dir, dir_nxt;
`endif

  assign key_pc1    = pc1(bus.key_in);
  assign last_round = (round == 4'(DES_ROUNDS - 1));

  des_pc2 u_pc2 (
    .cd ({c, d}),
    .k  (pc2_out)
  );

  // Next-state: load/start in IDLE, per-round rotation in RUN, restore C0/D0 at the end
  always_comb begin
    state_nxt = state;
    c0_nxt    = c0;
    d0_nxt    = d0;
    c_nxt     = c;
    d_nxt     = d;
    round_nxt = round;
    done_nxt  = 1'b0;
`ifdef DES_KEY_DECRYPT_EN
    dir_nxt   = dir;
`endif
    case (state)
      IDLE: begin
        if (bus.key_load) begin
          c0_nxt = key_pc1[55:28];
          d0_nxt = key_pc1[27:0];
          c_nxt  = key_pc1[55:28];
          d_nxt  = key_pc1[27:0];
        end else if (bus.start) begin
          state_nxt = RUN;
          round_nxt = 4'd0;
          c_nxt     = rotl28(c0, SHIFT_TAB[0]);
          d_nxt     = rotl28(d0, SHIFT_TAB[0]);
`ifdef DES_KEY_DECRYPT_EN
          dir_nxt = bus.decrypt;
          // Cumulative rotation of 28 makes the unshifted key K16
          if (bus.decrypt) begin
            c_nxt = c0;
            d_nxt = d0;
          end
`endif
        end
      end
      RUN: begin
        if (last_round) begin
          state_nxt = IDLE;
          round_nxt = 4'd0;
          c_nxt     = c0;
          d_nxt     = d0;
          done_nxt  = 1'b1;
        end else begin
          round_nxt = round + 4'd1;
          c_nxt     = rotl28(c, SHIFT_TAB[round + 4'd1]);
          d_nxt     = rotl28(d, SHIFT_TAB[round + 4'd1]);
`ifdef DES_KEY_DECRYPT_EN
          if (dir) begin
            c_nxt = rotr28(c, SHIFT_TAB[4'd15 - round]);
            d_nxt = rotr28(d, SHIFT_TAB[4'd15 - round]);
          end
`endif
        end
      end
      default: ;
    endcase
  end

  // State register; reset also clears the loaded key
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      c0    <= '0;
      d0    <= '0;
      c     <= '0;
      d     <= '0;
      round <= '0;
      done  <= 1'b0;
`ifdef DES_KEY_DECRYPT_EN
      dir   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      c0    <= c0_nxt;
      d0    <= d0_nxt;
      c     <= c_nxt;
      d     <= d_nxt;
      round <= round_nxt;
      done  <= done_nxt;
`ifdef DES_KEY_DECRYPT_EN
      dir   <= dir_nxt;
`endif
    end
  end

`ifdef DES_KEY_DECRYPT_EN
  assign restore_ok = dir ? ({rotr28(c, 2'd1), rotr28(d, 2'd1)} == {c0, d0})
                          : ({c, d} == {c0, d0});
`else
  assign restore_ok = ({c, d} == {c0, d0});
`endif

  // The schedule sums to a full 28-bit rotation, so the final restore is a no-op in value
  a_restore: assert property (@(posedge clk) disable iff (rst)
    (state == RUN && last_round) |-> restore_ok);

  assign bus.rkey_sel  = (state == RUN);
  assign bus.rkey_out  = (state == RUN) ? pc2_out : 48'd0;
  assign bus.round_idx = (state == RUN) ? round : 4'd0;
  assign bus.rkey_done = done;

endmodule
